// File: rtl/rob_retire.sv
// rob_retire: 16-entry reorder buffer with a 2-wide in-order retire stage.
//
// Dispatch allocates up to two entries per cycle in program order. Slot 1 is
// the older instruction. Slot 2 is accepted only alongside slot 1. The three
// functional units mark entries complete by ROB index. Up to two completed
// entries retire from the head each cycle. The retire outputs are registered
// and carry the old physical register, which goes back to the free pool.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   alloc_valid_1/2        dispatch requests (slot 1 older)
//   alloc_rd/pd/old_pd_*   arch dest, new phys dest, previous mapping
//   alloc_ready            at least two free entries (from registered count)
//   alloc_idx_1/2          indices handed back to dispatch (tail, tail+1)
//   cmp_valid_0..2/idx     completion notices from FU0/FU1 (ALU), FU2 (mem)
//   ret_valid_1/2          retire strobes, registered (slot 1 older)
//   ret_rd/pd/old_pd_*     fields of the retired entries, held when idle
//   count, empty, full     occupancy
//
// Optional feature: define ROB_FLUSH_EN to add a 'flush' input. Flush clears
// the whole buffer and takes priority over alloc, completion and retire.
module rob_retire #(
  parameter int ROB_DEPTH = 16,
  parameter int IDX_W     = 4,
  parameter int PREG_W    = 6
) (
  input  logic              clk,
  input  logic              reset,
`ifdef ROB_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              alloc_valid_1,
  input  logic [4:0]        alloc_rd_1,
  input  logic [PREG_W-1:0] alloc_pd_1,
  input  logic [PREG_W-1:0] alloc_old_pd_1,
  input  logic              alloc_valid_2,
  input  logic [4:0]        alloc_rd_2,
  input  logic [PREG_W-1:0] alloc_pd_2,
  input  logic [PREG_W-1:0] alloc_old_pd_2,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx_1,
  output logic [IDX_W-1:0]  alloc_idx_2,
  input  logic              cmp_valid_0,
  input  logic [IDX_W-1:0]  cmp_idx_0,
  input  logic              cmp_valid_1,
  input  logic [IDX_W-1:0]  cmp_idx_1,
  input  logic              cmp_valid_2,
  input  logic [IDX_W-1:0]  cmp_idx_2,
  output logic              ret_valid_1,
  output logic [4:0]        ret_rd_1,
  output logic [PREG_W-1:0] ret_pd_1,
  output logic [PREG_W-1:0] ret_old_pd_1,
  output logic              ret_valid_2,
  output logic [4:0]        ret_rd_2,
  output logic [PREG_W-1:0] ret_pd_2,
  output logic [PREG_W-1:0] ret_old_pd_2,
  output logic [IDX_W:0]    count,
  output logic              empty,
  output logic              full
);

  localparam logic [IDX_W:0]   CNT_MAX_ALLOC = (IDX_W+1)'(ROB_DEPTH - 2);
  localparam logic [IDX_W:0]   CNT_FULL      = (IDX_W+1)'(ROB_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE       = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_TWO       = IDX_W'(2);

  logic [ROB_DEPTH-1:0] valid_q, done_q;
  logic [ROB_DEPTH-1:0] valid_d, done_d;
  logic [ROB_DEPTH-1:0] alloc_mask, ret_mask, cmp_mask;
  logic [4:0]           rd_q     [ROB_DEPTH];
  logic [PREG_W-1:0]    pd_q     [ROB_DEPTH];
  logic [PREG_W-1:0]    old_pd_q [ROB_DEPTH];
  logic [IDX_W-1:0]     head_q, tail_q, head_p1, tail_p1;
  logic [IDX_W-1:0]     head_step, tail_step;
  logic [IDX_W:0]       count_q, count_d, n_acc, n_ret;
  logic                 flush_w;
  logic                 accept_1, accept_2, retire_1, retire_2;

`ifdef ROB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign head_p1     = head_q + IDX_ONE;
  assign tail_p1     = tail_q + IDX_ONE;
  assign alloc_idx_1 = tail_q;
  assign alloc_idx_2 = tail_p1;
  assign alloc_ready = (count_q <= CNT_MAX_ALLOC) && !flush_w;
  assign count       = count_q;
  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_FULL);

  assign accept_1 = alloc_ready && alloc_valid_1;
  assign accept_2 = accept_1 && alloc_valid_2;
  assign retire_1 = valid_q[head_q] && done_q[head_q];
  assign retire_2 = retire_1 && valid_q[head_p1] && done_q[head_p1];

  assign n_acc = {{IDX_W{1'b0}}, accept_1} + {{IDX_W{1'b0}}, accept_2};
  assign n_ret = {{IDX_W{1'b0}}, retire_1} + {{IDX_W{1'b0}}, retire_2};

  always_comb begin
    alloc_mask = '0;
    ret_mask   = '0;
    cmp_mask   = '0;
    if (accept_1)    alloc_mask[tail_q]  = 1'b1;
    if (accept_2)    alloc_mask[tail_p1] = 1'b1;
    if (retire_1)    ret_mask[head_q]    = 1'b1;
    if (retire_2)    ret_mask[head_p1]   = 1'b1;
    if (cmp_valid_0) cmp_mask[cmp_idx_0] = 1'b1;
    if (cmp_valid_1) cmp_mask[cmp_idx_1] = 1'b1;
    if (cmp_valid_2) cmp_mask[cmp_idx_2] = 1'b1;
  end

  // Completions only land on entries that were already valid; a fresh
  // allocation clears 'done' so it overrides a same-cycle completion.
  assign valid_d   = (valid_q & ~ret_mask) | alloc_mask;
  assign done_d    = (done_q | (cmp_mask & valid_q)) & ~ret_mask & ~alloc_mask;
  assign count_d   = count_q + n_acc - n_ret;
  assign head_step = retire_2 ? IDX_TWO : (retire_1 ? IDX_ONE : '0);
  assign tail_step = accept_2 ? IDX_TWO : (accept_1 ? IDX_ONE : '0);

  // ---- state update / retire stage boundary ----
  always_ff @(posedge clk) begin
    if (reset || flush_w) begin
      valid_q     <= '0;
      done_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ret_valid_1 <= 1'b0;
      ret_valid_2 <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      done_q      <= done_d;
      head_q      <= head_q + head_step;
      tail_q      <= tail_q + tail_step;
      count_q     <= count_d;
      ret_valid_1 <= retire_1;
      ret_valid_2 <= retire_2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ret_rd_1     <= '0;
      ret_pd_1     <= '0;
      ret_old_pd_1 <= '0;
      ret_rd_2     <= '0;
      ret_pd_2     <= '0;
      ret_old_pd_2 <= '0;
    end else if (!flush_w) begin
      if (retire_1) begin
        ret_rd_1     <= rd_q[head_q];
        ret_pd_1     <= pd_q[head_q];
        ret_old_pd_1 <= old_pd_q[head_q];
      end
      if (retire_2) begin
        ret_rd_2     <= rd_q[head_p1];
        ret_pd_2     <= pd_q[head_p1];
        ret_old_pd_2 <= old_pd_q[head_p1];
      end
    end
  end

  // Entry payload needs no reset: it is only read when its valid bit is set.
  always_ff @(posedge clk) begin
    if (accept_1) begin
      rd_q[tail_q]     <= alloc_rd_1;
      pd_q[tail_q]     <= alloc_pd_1;
      old_pd_q[tail_q] <= alloc_old_pd_1;
    end
    if (accept_2) begin
      rd_q[tail_p1]     <= alloc_rd_2;
      pd_q[tail_p1]     <= alloc_pd_2;
      old_pd_q[tail_p1] <= alloc_old_pd_2;
    end
  end

endmodule
